// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Keeps the PC and issues one fetch at a time to instruction memory over a
// valid/ready request channel whose response latency varies. A 1-entry hold
// buffer parks a returned instruction while decode is stalled. A redirect
// from EX repoints the PC and flushes IF/ID. If a fetch is still in flight
// when the redirect arrives, its later response is marked to be discarded.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        id_stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        ifid_valid,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc4,
  output logic [31:0] ifid_instr
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;      // PC of the fetch in flight / parked
  logic        kill_q, kill_d;          // in-flight response must be discarded
  logic [31:0] hold_instr_q, hold_instr_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;

  logic        load;        // write a fresh instruction into IF/ID this cycle
  logic [31:0] load_instr;  // from memory directly or from the hold buffer
  logic        accept;

  // A request is withheld during reset and in the redirect cycle, so the
  // first fetch to the new target starts the following cycle.
  assign imem_req_valid = !rst && (state_q == S_REQ) && !redirect_valid;
  assign imem_addr      = pc_q;
  assign accept         = imem_req_valid && imem_req_ready;

  assign ifid_valid = ifid_valid_q;
  assign ifid_pc    = ifid_pc_q;
  assign ifid_pc4   = ifid_pc4_q;
  assign ifid_instr = ifid_instr_q;

  // Next-state: redirect wins over everything, then the fetch FSM decides
  // whether IF/ID gets a new instruction, a bubble, or holds for the stall.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    kill_d       = kill_q;
    hold_instr_d = hold_instr_q;
    ifid_valid_d = ifid_valid_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_instr_d = ifid_instr_q;
    load         = 1'b0;
    load_instr   = imem_resp_data;

    if (redirect_valid) begin
      pc_d         = {redirect_pc[31:2], 2'b00};
      ifid_valid_d = 1'b0;
      ifid_instr_d = NOP_INSTR;
      state_d      = S_REQ;
      kill_d       = 1'b0;
      // Fetch still in flight: stay and swallow its response when it comes.
      if (state_q == S_WAIT && !imem_resp_valid) begin
        state_d = S_WAIT;
        kill_d  = 1'b1;
      end
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (accept) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + 32'd4;
            state_d  = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_resp_valid) begin
            state_d = S_REQ;
            if (kill_q) begin
              kill_d = 1'b0;
            end else if (!id_stall || !ifid_valid_q) begin
              load = 1'b1;
            end else begin
              hold_instr_d = imem_resp_data;
              state_d      = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!id_stall) begin
            load       = 1'b1;
            load_instr = hold_instr_q;
            state_d    = S_REQ;
          end
        end
        default: state_d = S_REQ;
      endcase

      if (load) begin
        ifid_valid_d = 1'b1;
        ifid_pc_d    = req_pc_q;
        ifid_pc4_d   = req_pc_q + 32'd4;
        ifid_instr_d = load_instr;
      end else if (!id_stall) begin
        // Decode consumed its instruction and nothing replaces it: bubble.
        ifid_valid_d = 1'b0;
      end
    end
  end

  // State and pipeline registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      req_pc_q     <= 32'h0;
      kill_q       <= 1'b0;
      hold_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
      ifid_pc_q    <= 32'h0;
      ifid_pc4_q   <= 32'h0;
      ifid_instr_q <= NOP_INSTR;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      kill_q       <= kill_d;
      hold_instr_q <= hold_instr_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_instr_q <= ifid_instr_d;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: a transaction-level model (queues of in-flight and
// parked fetches) checked against the DUT every cycle, plus directed
// vectors with literal expectations. A second instance covers RESET_PC
// wrap-around and asynchronous reset in the middle of a fetch.
module tb_if_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'h0;
  logic        id_stall, redirect_valid;
  logic [31:0] redirect_pc;
  logic        ifid_valid;
  logic [31:0] ifid_pc, ifid_pc4, ifid_instr;

  if_stage u_dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .id_stall(id_stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .ifid_valid(ifid_valid), .ifid_pc(ifid_pc), .ifid_pc4(ifid_pc4), .ifid_instr(ifid_instr)
  );

  // second instance, driven by hand
  logic        rst2, req_valid2, req_ready2, resp_valid2, stall2, redir2, ifid_valid2;
  logic [31:0] addr2, resp_data2, redir_pc2, ifid_pc2, ifid_pc4_2, ifid_instr2;

  if_stage #(.RESET_PC(32'hFFFF_FFFC)) u_dut2 (
    .clk(clk), .rst(rst2),
    .imem_req_valid(req_valid2), .imem_req_ready(req_ready2),
    .imem_addr(addr2),
    .imem_resp_valid(resp_valid2), .imem_resp_data(resp_data2),
    .id_stall(stall2), .redirect_valid(redir2), .redirect_pc(redir_pc2),
    .ifid_valid(ifid_valid2), .ifid_pc(ifid_pc2), .ifid_pc4(ifid_pc4_2), .ifid_instr(ifid_instr2)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] tag(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Instruction memory: answers each accepted request after lat cycles.
  int          lat = 1;
  int          cd = 0;
  logic [31:0] maddr = 32'h0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cd = 0;
    end else begin
      if (cd > 0) cd--;
      if (imem_req_valid && imem_req_ready) begin
        cd    = lat;
        maddr = imem_addr;
      end
    end
    #1;
    imem_resp_valid = (cd == 1) && !rst;
    imem_resp_data  = (cd == 1) ? tag(maddr) : 32'h0;
  end

  // Model: a fetch is either in flight (possibly doomed by a redirect) or
  // parked waiting for decode; a new request goes out only when neither exists.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    bit          killed;
  } fetch_t;

  fetch_t      inflight[$];
  fetch_t      parked[$];
  logic [31:0] m_pc;
  bit          mv;
  logic [31:0] mpc, mpc4, minstr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc = 32'h0;
      inflight.delete();
      parked.delete();
      mv = 0; mpc = 32'h0; mpc4 = 32'h0; minstr = NOP;
    end else begin
      fetch_t f;
      bit     loaded;
      loaded = 0;
      if (redirect_valid) begin
        m_pc   = redirect_pc & ~32'h3;
        mv     = 0;
        minstr = NOP;
        parked.delete();
        if (inflight.size() != 0) begin
          if (imem_resp_valid) inflight.delete();
          else inflight[0].killed = 1;
        end
      end else begin
        if (inflight.size() != 0 && imem_resp_valid) begin
          f = inflight.pop_front();
          if (!f.killed) begin
            f.instr = imem_resp_data;
            if (!id_stall || !mv) begin
              mv = 1; mpc = f.pc; mpc4 = f.pc + 32'd4; minstr = f.instr; loaded = 1;
            end else begin
              parked.push_back(f);
            end
          end
        end else if (parked.size() != 0 && !id_stall) begin
          f = parked.pop_front();
          mv = 1; mpc = f.pc; mpc4 = f.pc + 32'd4; minstr = f.instr; loaded = 1;
        end else if (inflight.size() == 0 && parked.size() == 0 && imem_req_ready) begin
          f.pc = m_pc; f.instr = 32'h0; f.killed = 0;
          inflight.push_back(f);
          m_pc = m_pc + 32'd4;
        end
        if (!loaded && !id_stall) mv = 0;
      end
    end
  end

  // Compare DUT against the model every cycle, mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
      chk("rst_ifid_valid", {31'h0, ifid_valid}, 32'h0);
      chk("rst_ifid_pc", ifid_pc, 32'h0);
      chk("rst_ifid_pc4", ifid_pc4, 32'h0);
      chk("rst_ifid_instr", ifid_instr, NOP);
    end else begin
      bit exp_req;
      exp_req = inflight.size() == 0 && parked.size() == 0 && !redirect_valid;
      chk("m_req_valid", {31'h0, imem_req_valid}, {31'h0, exp_req});
      if (exp_req) chk("m_imem_addr", imem_addr, m_pc);
      chk("m_ifid_valid", {31'h0, ifid_valid}, {31'h0, mv});
      chk("m_ifid_pc", ifid_pc, mpc);
      chk("m_ifid_pc4", ifid_pc4, mpc4);
      chk("m_ifid_instr", ifid_instr, minstr);
      if (imem_resp_valid) chk("m_resp_outstanding", 32'(inflight.size()), 32'd1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] pat_s, pat_r;
    pat_s = 48'h0F0_3C1_8E7_0C3;
    pat_r = 48'hFDF_7BE_FF6_EFB;
    rst = 1; imem_req_ready = 1; id_stall = 0; redirect_valid = 0; redirect_pc = 32'h0;
    rst2 = 1; req_ready2 = 1; resp_valid2 = 0; resp_data2 = 32'h0; stall2 = 0;
    redir2 = 0; redir_pc2 = 32'h0;
    repeat (3) cyc();
    chk("t0_req_valid", {31'h0, imem_req_valid}, 32'h0);
    chk("t0_instr", ifid_instr, NOP);

    // 1: 1-cycle memory, fetch stream 0,4,... with a valid every 2nd cycle
    rst = 0;
    chk("t1_addr0", imem_addr, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      cyc();
      chk("t1_valid", {31'h0, ifid_valid}, (i % 2 == 0) ? 32'h1 : 32'h0);
      if (i % 2 == 0) begin
        chk("t1_pc", ifid_pc, 32'((i / 2 - 1) * 4));
        chk("t1_pc4", ifid_pc4, 32'((i / 2) * 4));
      end
    end
    chk("t1_addr8", imem_addr, 32'h8);

    // 2: stall while the 0x8 response returns; it parks, no new request
    id_stall = 1;
    cyc();
    for (int j = 0; j < 2; j++) begin
      cyc();
      chk("t2_hold_pc", ifid_pc, 32'h4);
      chk("t2_hold_valid", {31'h0, ifid_valid}, 32'h1);
      chk("t2_no_req", {31'h0, imem_req_valid}, 32'h0);
    end
    id_stall = 0;
    cyc();
    chk("t2_pc8", ifid_pc, 32'h8);
    chk("t2_pc4_12", ifid_pc4, 32'hC);
    chk("t2_instr", ifid_instr, tag(32'h8));

    // 3: redirect while waiting, response arrives later and is dropped
    lat = 3;
    cyc();
    redirect_valid = 1; redirect_pc = 32'h103;
    cyc();
    redirect_valid = 0;
    chk("t3_flush_valid", {31'h0, ifid_valid}, 32'h0);
    chk("t3_wait_noreq", {31'h0, imem_req_valid}, 32'h0);
    cyc();
    chk("t3_drop_valid", {31'h0, ifid_valid}, 32'h0);
    cyc();
    chk("t3_req", {31'h0, imem_req_valid}, 32'h1);
    chk("t3_addr", imem_addr, 32'h100);
    chk("t3_still_empty", {31'h0, ifid_valid}, 32'h0);
    lat = 1;
    cyc(); cyc();
    chk("t3_land_valid", {31'h0, ifid_valid}, 32'h1);
    chk("t3_land_pc", ifid_pc, 32'h100);

    // 4: redirect coincident with a response under id_stall
    id_stall = 1; lat = 2;
    cyc(); cyc();
    chk("t4_pre_pc", ifid_pc, 32'h100);
    redirect_valid = 1; redirect_pc = 32'h200;
    cyc();
    redirect_valid = 0;
    chk("t4_flush_valid", {31'h0, ifid_valid}, 32'h0);
    chk("t4_flush_instr", ifid_instr, NOP);
    chk("t4_addr", imem_addr, 32'h200);

    // 5: memory not ready for 5 cycles, request held steady
    id_stall = 0; imem_req_ready = 0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("t5_req_held", {31'h0, imem_req_valid}, 32'h1);
      chk("t5_addr_held", imem_addr, 32'h200);
    end
    imem_req_ready = 1; lat = 1;
    cyc(); cyc();
    chk("t5_land_pc", ifid_pc, 32'h200);

    // directed mix of stall/ready/latency/redirect, checked by the model
    for (int i = 0; i < 48; i++) begin
      id_stall       = pat_s[i];
      imem_req_ready = pat_r[i];
      lat            = 1 + i % 3;
      redirect_valid = (i % 11 == 5);
      redirect_pc    = (i == 27) ? 32'hFFFF_FFF9 : 32'h300 + 32'(i * 12 + i % 4);
      cyc();
    end
    redirect_valid = 0; id_stall = 0; imem_req_ready = 1;
    repeat (10) cyc();

    // 6: RESET_PC at the top of memory wraps; async reset mid-fetch
    rst2 = 0;
    chk("t6_addr0", addr2, 32'hFFFF_FFFC);
    cyc();
    chk("t6_wait_noreq", {31'h0, req_valid2}, 32'h0);
    resp_valid2 = 1; resp_data2 = 32'h1234_5013;
    cyc();
    resp_valid2 = 0;
    chk("t6_valid", {31'h0, ifid_valid2}, 32'h1);
    chk("t6_pc", ifid_pc2, 32'hFFFF_FFFC);
    chk("t6_pc4_wrap", ifid_pc4_2, 32'h0);
    chk("t6_instr", ifid_instr2, 32'h1234_5013);
    chk("t6_addr_wrap", addr2, 32'h0);
    cyc();
    #1;
    rst2 = 1;
    #1;
    chk("t6_rst_req", {31'h0, req_valid2}, 32'h0);
    chk("t6_rst_valid", {31'h0, ifid_valid2}, 32'h0);
    chk("t6_rst_pc", ifid_pc2, 32'h0);
    chk("t6_rst_pc4", ifid_pc4_2, 32'h0);
    chk("t6_rst_instr", ifid_instr2, NOP);
    cyc();
    rst2 = 0;
    chk("t6_addr_again", addr2, 32'hFFFF_FFFC);
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
